// File: rtl/mbscore_wb_arbiter_pkg.sv
// MBScore writeback arbiter shared constants.
// Register-file geometry and requester indices.
package mbscore_wb_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int WB_NREQ        = 3;
  localparam int WB_CNT_W       = 2;

  typedef enum int {
    WB_REQ_ALU = 0,
    WB_REQ_LSU = 1,
    WB_REQ_MDU = 2
  } wb_req_e;

  function automatic int rr_next(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/mbscore_wb_arbiter_if.sv
// Writeback requester bus plus the registered
// register-file write port it feeds.
interface mbscore_wb_arbiter_if
  import mbscore_wb_arbiter_pkg::*;
#(
  parameter int NREQ   = WB_NREQ,
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_spr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;

  logic                   wb_we;
  logic                   wb_spr_we;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;

  modport master (
    output req_valid,
    output req_spr,
    output req_addr,
    output req_data,
    input  req_ready,
    input  wb_we,
    input  wb_spr_we,
    input  wb_addr,
    input  wb_data
  );

  modport slave (
    input  req_valid,
    input  req_spr,
    input  req_addr,
    input  req_data,
    output req_ready,
    output wb_we,
    output wb_spr_we,
    output wb_addr,
    output wb_data
  );

endinterface

// File: rtl/mbscore_rr_arbiter.sv
// Round-robin pick: search starts at ptr,
// first valid requester wins.
module mbscore_rr_arbiter #(
  parameter  int NREQ  = 3,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && valid[pos]) begin
        grant[pos] = 1'b1;
        idx        = PTR_W'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbscore_wb_arbiter.sv
// Writeback port arbiter with registered write
// and GPR pending-write scoreboard.
module mbscore_wb_arbiter
  import mbscore_wb_arbiter_pkg::*;
#(
  parameter  int NREQ   = WB_NREQ,
  parameter  int CNT_W  = WB_CNT_W,
  parameter  int ADDR_W = REG_ADDR_WIDTH,
  parameter  int DATA_W = DATA_WIDTH,
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  mbscore_wb_arbiter_if.slave bus,
  input  logic              sb_set_valid,
  input  logic [ADDR_W-1:0] sb_set_addr,
  output logic              sb_set_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [PTR_W-1:0]  ptr;
  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  idx;
  logic              any;

  logic              sel_spr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_gpr;

  logic              set_en;
  logic              clr_en;
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   dec;

  logic [CNT_W-1:0]  cnt [NREG];

  mbscore_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign bus.req_ready = rst ? '0 : grant;

  assign sel_spr  = bus.req_spr[idx];
  assign sel_addr = bus.req_addr[idx*ADDR_W +: ADDR_W];
  assign sel_data = bus.req_data[idx*DATA_W +: DATA_W];
  assign sel_gpr  = !sel_spr && (sel_addr != '0);

  assign sb_set_ready = (cnt[sb_set_addr] != '1);

  assign set_en = sb_set_valid && sb_set_ready
               && (sb_set_addr != '0);
  assign clr_en = any && sel_gpr;

  assign inc = set_en ? (NREG'(1) << sb_set_addr) : '0;
  assign dec = clr_en ? (NREG'(1) << sel_addr) : '0;

  assign rs_busy = (cnt[rs_addr] != '0);
  assign rt_busy = (cnt[rt_addr] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= PTR_W'(rr_next(int'(idx), NREQ));
    end
  end

  // r0 is never set or cleared, so cnt[0] stays 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < NREG; a++) begin
        cnt[a] <= '0;
      end
    end else begin
      for (int a = 0; a < NREG; a++) begin
        if (inc[a] && !dec[a]) begin
          cnt[a] <= cnt[a] + 1'b1;
        end else if (dec[a] && !inc[a]
                     && cnt[a] != '0) begin
          cnt[a] <= cnt[a] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_we     <= 1'b0;
      bus.wb_spr_we <= 1'b0;
      bus.wb_addr   <= '0;
      bus.wb_data   <= '0;
    end else if (any) begin
      bus.wb_we     <= sel_gpr;
      bus.wb_spr_we <= sel_spr;
      bus.wb_addr   <= sel_addr;
      bus.wb_data   <= sel_data;
    end else begin
      bus.wb_we     <= 1'b0;
      bus.wb_spr_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mbscore_wb_arbiter.sv
// Bench for mbscore_wb_arbiter: directed tables,
// hand sequences and randomized model comparison.
module tb_mbscore_wb_arbiter;

  logic       clk;
  logic       rst;
  logic       sb_set_valid;
  logic [4:0] sb_set_addr;
  logic       sb_set_ready;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic       rs_busy;
  logic       rt_busy;

  mbscore_wb_arbiter_if #(
    .NREQ(3), .ADDR_W(5), .DATA_W(32)
  ) bus ();

  mbscore_wb_arbiter #(
    .NREQ(3), .CNT_W(2), .ADDR_W(5), .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sb_set_valid (sb_set_valid),
    .sb_set_addr  (sb_set_addr),
    .sb_set_ready (sb_set_ready),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_busy      (rs_busy),
    .rt_busy      (rt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          m_ptr;
  int          m_cnt [32];
  logic        e_we;
  logic        e_swe;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  int          last_win;
  logic [2:0]  last_ready;

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  s;
    logic [14:0] a;
    logic [2:0]  rdy;
    logic        we;
    logic        swe;
    logic [4:0]  wa;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    e_we   = 1'b0;
    e_swe  = 1'b0;
    e_addr = '0;
    e_data = '0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic [2:0]  v,
                       input logic [2:0]  s,
                       input logic [14:0] a,
                       input logic [95:0] d,
                       input logic        sv,
                       input logic [4:0]  sa,
                       input logic [4:0]  rs,
                       input logic [4:0]  rt);
    int win;
    int ii;
    int wa;
    bit set;
    bit clr;
    bus.req_valid = v;
    bus.req_spr   = s;
    bus.req_addr  = a;
    bus.req_data  = d;
    sb_set_valid  = sv;
    sb_set_addr   = sa;
    rs_addr       = rs;
    rt_addr       = rt;
    #1;
    win = -1;
    for (int k = 0; k < 3; k++) begin
      ii = (m_ptr + k) % 3;
      if (win < 0 && v[ii]) win = ii;
    end
    chk("req_ready", 32'(bus.req_ready),
        (win < 0) ? 0 : (1 << win));
    chk("sb_set_ready", 32'(sb_set_ready),
        32'(m_cnt[sa] != 3));
    chk("rs_busy", 32'(rs_busy), 32'(m_cnt[rs] != 0));
    chk("rt_busy", 32'(rt_busy), 32'(m_cnt[rt] != 0));
    last_win   = win;
    last_ready = bus.req_ready;
    @(posedge clk);
    set = sv && sa != 0 && m_cnt[sa] < 3;
    clr = 1'b0;
    wa  = 0;
    if (win >= 0) begin
      wa     = int'(a[win*5 +: 5]);
      clr    = !s[win] && wa != 0;
      e_we   = clr;
      e_swe  = s[win];
      e_addr = a[win*5 +: 5];
      e_data = d[win*32 +: 32];
      m_ptr  = (win + 1) % 3;
    end else begin
      e_we  = 1'b0;
      e_swe = 1'b0;
    end
    if (set) m_cnt[sa]++;
    if (clr && m_cnt[wa] > 0) m_cnt[wa]--;
    #1;
    chk("wb_we", 32'(bus.wb_we), 32'(e_we));
    chk("wb_spr_we", 32'(bus.wb_spr_we), 32'(e_swe));
    chk("wb_addr", 32'(bus.wb_addr), 32'(e_addr));
    chk("wb_data", bus.wb_data, e_data);
  endtask

  logic [95:0] dd;
  logic [2:0]  cur_v;
  logic [2:0]  cur_s;
  logic [14:0] cur_a;
  logic [95:0] cur_d;

  initial begin
    dd = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    tbl[0] = '{3'b111, 3'b000, {5'd3, 5'd2, 5'd1},
               3'b001, 1'b1, 1'b0, 5'd1};
    tbl[1] = '{3'b111, 3'b000, {5'd3, 5'd2, 5'd1},
               3'b010, 1'b1, 1'b0, 5'd2};
    tbl[2] = '{3'b111, 3'b000, {5'd3, 5'd2, 5'd1},
               3'b100, 1'b1, 1'b0, 5'd3};
    tbl[3] = '{3'b111, 3'b000, {5'd3, 5'd2, 5'd1},
               3'b001, 1'b1, 1'b0, 5'd1};
    tbl[4] = '{3'b010, 3'b000, {5'd0, 5'd0, 5'd0},
               3'b010, 1'b0, 1'b0, 5'd0};
    tbl[5] = '{3'b100, 3'b100, {5'd3, 5'd0, 5'd0},
               3'b100, 1'b0, 1'b1, 5'd3};
    tbl[6] = '{3'b000, 3'b000, {5'd0, 5'd0, 5'd0},
               3'b000, 1'b0, 1'b0, 5'd3};

    rst           = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_spr   = '0;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_data  = dd;
    sb_set_valid  = 1'b0;
    sb_set_addr   = '0;
    rs_addr       = 5'd1;
    rt_addr       = 5'd2;
    model_reset();
    #12;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_we", 32'(bus.wb_we), 0);
    chk("rst_spr_we", 32'(bus.wb_spr_we), 0);
    chk("rst_addr", 32'(bus.wb_addr), 0);
    chk("rst_data", bus.wb_data, 0);
    chk("rst_busy", 32'(rs_busy), 0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin order, r0 write and SPR write.
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].a, dd,
            1'b0, 5'd0, 5'd0, 5'd0);
      chk("tbl_ready", 32'(last_ready), 32'(tbl[i].rdy));
      chk("tbl_we", 32'(bus.wb_we), 32'(tbl[i].we));
      chk("tbl_spr_we", 32'(bus.wb_spr_we),
          32'(tbl[i].swe));
      chk("tbl_addr", 32'(bus.wb_addr), 32'(tbl[i].wa));
    end

    // Single ALU write, one-cycle latency and pulse.
    cycle(3'b001, 3'b000, {10'd0, 5'd5},
          {64'd0, 32'hDEAD_BEEF}, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("alu_ready", 32'(last_ready), 32'h1);
    chk("alu_we", 32'(bus.wb_we), 1);
    chk("alu_addr", 32'(bus.wb_addr), 5);
    chk("alu_data", bus.wb_data, 32'hDEAD_BEEF);
    cycle(3'b000, 3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("alu_we_drop", 32'(bus.wb_we), 0);

    // Saturate r7, then drain it with three clears.
    for (int i = 0; i < 3; i++)
      cycle(3'b000, 3'b000, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    cycle(3'b000, 3'b000, '0, '0, 1'b0, 5'd7, 5'd7, 5'd0);
    chk("r7_sat", 32'(sb_set_ready), 0);
    cycle(3'b001, 3'b000, {10'd0, 5'd7}, '0,
          1'b0, 5'd0, 5'd7, 5'd0);
    chk("r7_busy1", 32'(rs_busy), 1);
    cycle(3'b001, 3'b000, {10'd0, 5'd7}, '0,
          1'b0, 5'd0, 5'd7, 5'd0);
    chk("r7_busy2", 32'(rs_busy), 1);
    cycle(3'b001, 3'b000, {10'd0, 5'd7}, '0,
          1'b0, 5'd0, 5'd7, 5'd0);
    chk("r7_free", 32'(rs_busy), 0);

    // Same-cycle set and clear of r3 cancel out.
    cycle(3'b000, 3'b000, '0, '0, 1'b1, 5'd3, 5'd3, 5'd0);
    cycle(3'b001, 3'b000, {10'd0, 5'd3}, '0,
          1'b1, 5'd3, 5'd3, 5'd0);
    chk("r3_hold", 32'(rs_busy), 1);
    cycle(3'b001, 3'b000, {10'd0, 5'd3}, '0,
          1'b0, 5'd0, 5'd3, 5'd0);
    chk("r3_free", 32'(rs_busy), 0);

    // Asynchronous reset mid-cycle with work in flight.
    cycle(3'b000, 3'b000, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    cycle(3'b001, 3'b000, {10'd0, 5'd4}, '0,
          1'b0, 5'd0, 5'd9, 5'd0);
    chk("pre_rst_we", 32'(bus.wb_we), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_we", 32'(bus.wb_we), 0);
    chk("async_ready", 32'(bus.req_ready), 0);
    chk("async_busy", 32'(rs_busy), 0);
    model_reset();
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic; requests held until accepted.
    cur_v = '0;
    cur_s = '0;
    cur_a = '0;
    cur_d = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!cur_v[i]) begin
          cur_v[i] = ($urandom_range(0, 9) < 6);
          cur_s[i] = ($urandom_range(0, 5) == 0);
          cur_a[i*5 +: 5]  = 5'($urandom_range(0, 7));
          cur_d[i*32 +: 32] = $urandom;
        end
      end
      cycle(cur_v, cur_s, cur_a, cur_d,
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      if (last_win >= 0) cur_v[last_win] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
